urgent_rr_scheduler: RTL and testbench
======================================

# urgent_rr_scheduler

Sequential two-class round-robin scheduler for N requesters sharing one resource. It is the clocked successor to the combinational urgent/normal selector. Each requester raises `ready` (normal) and/or `ready_urgent`. The block issues a registered one-hot grant and holds it until the resource reports `done`. Urgent requests always beat normal ones, and each class rotates fairly. An optional starvation guard promotes long-waiting normal requesters.

## Interface
- `N`, default 8: number of requesters (2..32).
- `STARVE_LIMIT`, default 15: wait cycles before a normal requester is promoted. Used only with `URS_STARVE_PROMOTE_EN`.
- `CNT_W`, default `$clog2(STARVE_LIMIT+1)`: starvation counter width.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `ready`, input, N: normal request per requester.
- `ready_urgent`, input, N: urgent request per requester.
- `done`, input, 1: current grantee releases the resource this cycle.
- `sel`, output, N: registered one-hot grant; all zero when idle.
- `sel_valid`, output, 1: `sel` holds a valid grant.
- `sel_valid_urgent`, output, 1: the current grant was issued from the urgent class.

## Operation
- FSM states are IDLE and GRANT.
- **IDLE**
  - If any bit of `ready_urgent` is set, pick one using the urgent pointer `uptr`.
  - Otherwise, if any bit of `ready` is set, pick one using the normal pointer `nptr`.
  - Otherwise stay in IDLE.
  - A pick loads `sel`, `sel_valid` and `sel_valid_urgent`, and moves to GRANT.
- **GRANT**
  - `sel` is frozen while `done`=0.
  - Request inputs are ignored for the held grant, including withdrawal by the grantee.
  - On `done`=1 the block re-arbitrates in the same cycle. If any request exists, the next grant loads with no idle gap. Otherwise it returns to IDLE with `sel`=0.
- **Round-robin pick:** the first set bit at or after the pointer index, searching upward and wrapping N-1 → 0.
  - After a grant to index i, that class's pointer becomes (i+1) mod N. The other class's pointer is unchanged.
- **Same index in both classes:** if a requester asserts both `ready[i]` and `ready_urgent[i]`, it competes only as urgent.
- `done` is ignored in IDLE.

## Timing
- Request-to-grant latency is 1 cycle: a request sampled at edge k yields `sel` valid after edge k.
- Back-to-back grants: with `done`=1 at edge k and requests pending, the new `sel` is visible after edge k.
- Minimum grant length is 1 cycle (`done` asserted on the first grant cycle).
- Reset values:
  - `sel`=0, `sel_valid`=0, `sel_valid_urgent`=0.
  - `uptr`=0, `nptr`=0.
  - State IDLE; all starvation counters 0.
- Reset asserted mid-grant drops the grant at that edge. Inputs are ignored while `rst`=1.
- `sel_valid` = |`sel` at all times. `sel_valid_urgent` implies `sel_valid`.

## Configuration
- **`URS_STARVE_PROMOTE_EN` defined**
  - Each requester has a CNT_W-bit counter.
  - The counter increments each cycle while `ready[i]`=1 and `sel[i]`=0, saturating at `STARVE_LIMIT`.
  - The counter clears when `ready[i]`=0 or when i is granted.
  - A requester whose counter equals `STARVE_LIMIT` is OR'd into the urgent candidate set.
  - If a promoted requester is selected, the grant reports `sel_valid_urgent`=1 and advances `uptr`.
- **Not defined:** no counters; strict urgent-over-normal priority; normal requesters can starve.

## Structure
- Shared package `urs_pkg` holds:
  - the FSM state enum (`URS_IDLE`, `URS_GRANT`);
  - the `URS_MAX_N`=32 constant.
- One sub-module, `rr_pick`: combinational, parameter N. It takes `req[N]` and `ptr`, and returns a one-hot `gnt[N]`, the grant index `idx`, and `any`.
  - It is instantiated twice, once for the urgent class and once for the normal class.

## Test plan
- **Reset and idle:** `rst`=1 for 2 cycles, then `ready`=0 and `ready_urgent`=0 → `sel`=0, both valids 0, and `sel` stays 0 in following cycles.
- **Urgent priority:** `ready`=8'b00000100, `ready_urgent`=8'b00000010 → next cycle `sel`=8'b00000010, `sel_valid_urgent`=1. After `done`, `sel`=8'b00000100 with `sel_valid_urgent`=0.
- **Normal rotation with wrap:** `ready`=8'b10000001 held, `done` pulsed every cycle → grants alternate 0x01, 0x80, 0x01, 0x80.
- **Hold until done:** grant 8'b00001000, drop `ready[3]`, keep `done`=0 for 5 cycles → `sel` stays 8'b00001000. On `done`, it moves to the next pending requester or to 0.
- **Reset mid-grant:** `rst`=1 while `sel`=8'b00010000 → `sel`=0 after that edge, and both pointers read 0 on the first post-reset arbitration (grant to the lowest requester).
- **Starvation (`URS_STARVE_PROMOTE_EN`, STARVE_LIMIT=3):** `ready_urgent`=8'b00000011 continuously with `done` every cycle, plus `ready`=8'b00100000 → bit 5 is granted as urgent within 4 cycles of being asserted, and its counter clears. Without the macro, bit 5 is never granted.

Source files
------------

// File: rtl/urs_pkg.sv
// urs_pkg: shared types and constants for the urgent round-robin scheduler.
// Holds the scheduler FSM state enum and the maximum requester count.
package urs_pkg;

   localparam int URS_MAX_N = 32;

   typedef enum logic {
      URS_IDLE  = 1'b0,
      URS_GRANT = 1'b1
   } urs_state_e;

endpackage

// File: rtl/urgent_rr_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker for one request class.
// Ports: req (requests), ptr (search start index), gnt (one-hot winner),
//        idx (winner index), any (at least one request present).
module rr_pick #(
   parameter int N  = 8,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   // Walk upward from ptr with wrap; the first set bit wins.
   always_comb begin
      int unsigned j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/urgent_rr_scheduler.sv
// urgent_rr_scheduler: registered two-class round-robin grant, held until done.
// Ports: clk, rst (sync, active high), ready / ready_urgent (requests),
//        done (grantee release), sel (one-hot grant), sel_valid,
//        sel_valid_urgent (grant came from the urgent class).
// Option: define URS_STARVE_PROMOTE_EN to promote starving normal requesters.
module urgent_rr_scheduler
   import urs_pkg::*;
#(
   parameter int N            = 8,
   parameter int STARVE_LIMIT = 15,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] ready,
   input  logic [N-1:0] ready_urgent,
   input  logic         done,
   output logic [N-1:0] sel,
   output logic         sel_valid,
   output logic         sel_valid_urgent
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   urs_state_e    r_state, w_nxt_state;
   logic [N-1:0]  r_sel, w_nxt_sel;
   logic          r_urg, w_nxt_urg;
   logic [PW-1:0] r_uptr, w_nxt_uptr;
   logic [PW-1:0] r_nptr, w_nxt_nptr;

   logic [N-1:0]  w_promo;
   logic [N-1:0]  w_ucand, w_ncand;
   logic [N-1:0]  w_u_gnt, w_n_gnt;
   logic [PW-1:0] w_u_idx, w_n_idx;
   logic          w_u_any, w_n_any;
   logic          w_arb;

`ifdef URS_STARVE_PROMOTE_EN
   logic [CNT_W-1:0] r_cnt [N];

   // A grant (current or being loaded) resets the wait count.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!ready[i] || r_sel[i] || w_nxt_sel[i])
               r_cnt[i] <= '0;
            else if (r_cnt[i] != CNT_W'(STARVE_LIMIT))
               r_cnt[i] <= r_cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      w_promo = '0;
      for (int i = 0; i < N; i++)
         w_promo[i] = ready[i] && (r_cnt[i] == CNT_W'(STARVE_LIMIT));
   end
`else
   assign w_promo = '0;
`endif

   // A requester present in the urgent set never competes as normal.
   assign w_ucand = ready_urgent | w_promo;
   assign w_ncand = ready & ~w_ucand;

   rr_pick #(.N(N), .PW(PW)) u_pick_urg (
      .req (w_ucand),
      .ptr (r_uptr),
      .gnt (w_u_gnt),
      .idx (w_u_idx),
      .any (w_u_any)
   );

   rr_pick #(.N(N), .PW(PW)) u_pick_nrm (
      .req (w_ncand),
      .ptr (r_nptr),
      .gnt (w_n_gnt),
      .idx (w_n_idx),
      .any (w_n_any)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_sel   = r_sel;
      w_nxt_urg   = r_urg;
      w_nxt_uptr  = r_uptr;
      w_nxt_nptr  = r_nptr;
      w_arb       = 1'b0;
      unique case (r_state)
         URS_IDLE:  w_arb = 1'b1;
         URS_GRANT: w_arb = done;
         default:   w_arb = 1'b1;
      endcase
      if (w_arb) begin
         if (w_u_any) begin
            w_nxt_state = URS_GRANT;
            w_nxt_sel   = w_u_gnt;
            w_nxt_urg   = 1'b1;
            w_nxt_uptr  = (w_u_idx == PW'(N - 1)) ? '0 : w_u_idx + 1'b1;
         end else if (w_n_any) begin
            w_nxt_state = URS_GRANT;
            w_nxt_sel   = w_n_gnt;
            w_nxt_urg   = 1'b0;
            w_nxt_nptr  = (w_n_idx == PW'(N - 1)) ? '0 : w_n_idx + 1'b1;
         end else begin
            w_nxt_state = URS_IDLE;
            w_nxt_sel   = '0;
            w_nxt_urg   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= URS_IDLE;
         r_sel   <= '0;
         r_urg   <= 1'b0;
         r_uptr  <= '0;
         r_nptr  <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_sel   <= w_nxt_sel;
         r_urg   <= w_nxt_urg;
         r_uptr  <= w_nxt_uptr;
         r_nptr  <= w_nxt_nptr;
      end
   end

   assign sel              = r_sel;
   assign sel_valid        = |r_sel;
   assign sel_valid_urgent = r_urg;

endmodule

// File: tb/tb_urgent_rr_scheduler.sv
// tb_urgent_rr_scheduler: directed vectors with a queue-based scoreboard.
// Define URS_STARVE_PROMOTE_EN for both bench and RTL to exercise promotion.
module tb_urgent_rr_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ready;
   logic [7:0] ready_urgent;
   logic       done;
   logic [7:0] sel;
   logic       sel_valid;
   logic       sel_valid_urgent;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string      tag;
      logic [7:0] sel;
      logic       urg;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   urgent_rr_scheduler #(
      .N            (8),
      .STARVE_LIMIT (3)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .ready            (ready),
      .ready_urgent     (ready_urgent),
      .done             (done),
      .sel              (sel),
      .sel_valid        (sel_valid),
      .sel_valid_urgent (sel_valid_urgent)
   );

   // Monitor: one expected entry per clock, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if (sel !== e.sel || sel_valid !== (|e.sel) ||
                sel_valid_urgent !== e.urg) begin
               n_fail++;
               $display("FAIL %s: sel=%h v=%b u=%b, expected sel=%h v=%b u=%b",
                        e.tag, sel, sel_valid, sel_valid_urgent,
                        e.sel, |e.sel, e.urg);
            end
         end
      end
   end

   task automatic cyc(input string tag, input logic r,
                      input logic [7:0] rdy, input logic [7:0] urg,
                      input logic dn, input logic [7:0] esel,
                      input logic eurg);
      exp_t e;
      @(negedge clk);
      #1;
      rst          = r;
      ready        = rdy;
      ready_urgent = urg;
      done         = dn;
      e.tag = tag;
      e.sel = esel;
      e.urg = eurg;
      q.push_back(e);
   endtask

   initial begin
      rst          = 1'b1;
      ready        = '0;
      ready_urgent = '0;
      done         = 1'b0;

      cyc("reset0", 1, 8'h00, 8'h00, 0, 8'h00, 0);
      cyc("reset1", 1, 8'h00, 8'h00, 0, 8'h00, 0);
      cyc("idle0",  0, 8'h00, 8'h00, 0, 8'h00, 0);
      cyc("idle1",  0, 8'h00, 8'h00, 1, 8'h00, 0);
      cyc("idle2",  0, 8'h00, 8'h00, 0, 8'h00, 0);

      cyc("rot0",   0, 8'h81, 8'h00, 1, 8'h01, 0);
      cyc("rot1",   0, 8'h81, 8'h00, 1, 8'h80, 0);
      cyc("rot2",   0, 8'h81, 8'h00, 1, 8'h01, 0);
      cyc("rot3",   0, 8'h81, 8'h00, 1, 8'h80, 0);
      cyc("rotend", 0, 8'h00, 8'h00, 1, 8'h00, 0);

      cyc("upri0",  0, 8'h04, 8'h02, 0, 8'h02, 1);
      cyc("upri1",  0, 8'h04, 8'h00, 1, 8'h04, 0);
      cyc("upri2",  0, 8'h00, 8'h00, 1, 8'h00, 0);

      cyc("hold0",  0, 8'h08, 8'h00, 0, 8'h08, 0);
      cyc("hold1",  0, 8'h20, 8'h00, 0, 8'h08, 0);
      cyc("hold2",  0, 8'h20, 8'h01, 0, 8'h08, 0);
      cyc("hold3",  0, 8'h20, 8'h00, 0, 8'h08, 0);
      cyc("hold4",  0, 8'h20, 8'h00, 0, 8'h08, 0);
      cyc("hold5",  0, 8'h20, 8'h00, 0, 8'h08, 0);
      cyc("holdnx", 0, 8'h20, 8'h00, 1, 8'h20, 0);
      cyc("holdend",0, 8'h00, 8'h00, 1, 8'h00, 0);

      cyc("mrst0",  0, 8'h10, 8'h00, 0, 8'h10, 0);
      cyc("mrst1",  1, 8'h10, 8'h00, 0, 8'h00, 0);
      cyc("mrstn",  0, 8'h30, 8'h00, 0, 8'h10, 0);
      cyc("mrstu",  0, 8'h00, 8'h06, 1, 8'h02, 1);
      cyc("mrstend",0, 8'h00, 8'h00, 1, 8'h00, 0);

      cyc("both0",  0, 8'h04, 8'h04, 0, 8'h04, 1);
      cyc("both1",  0, 8'h04, 8'h00, 1, 8'h04, 0);
      cyc("bothend",0, 8'h00, 8'h00, 1, 8'h00, 0);

`ifdef URS_STARVE_PROMOTE_EN
      cyc("stv0",   0, 8'h20, 8'h03, 1, 8'h01, 1);
      cyc("stv1",   0, 8'h20, 8'h03, 1, 8'h02, 1);
      cyc("stv2",   0, 8'h20, 8'h03, 1, 8'h01, 1);
      cyc("stv3",   0, 8'h20, 8'h03, 1, 8'h02, 1);
      cyc("stv4",   0, 8'h20, 8'h03, 1, 8'h20, 1);
      cyc("stv5",   0, 8'h20, 8'h03, 1, 8'h01, 1);
      cyc("stv6",   0, 8'h20, 8'h03, 1, 8'h02, 1);
`else
      cyc("stv0",   0, 8'h20, 8'h03, 1, 8'h01, 1);
      cyc("stv1",   0, 8'h20, 8'h03, 1, 8'h02, 1);
      cyc("stv2",   0, 8'h20, 8'h03, 1, 8'h01, 1);
      cyc("stv3",   0, 8'h20, 8'h03, 1, 8'h02, 1);
      cyc("stv4",   0, 8'h20, 8'h03, 1, 8'h01, 1);
      cyc("stv5",   0, 8'h20, 8'h03, 1, 8'h02, 1);
      cyc("stv6",   0, 8'h20, 8'h03, 1, 8'h01, 1);
`endif
      cyc("stvend", 0, 8'h00, 8'h00, 1, 8'h00, 0);
      cyc("final",  0, 8'h00, 8'h00, 0, 8'h00, 0);

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #2;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
